curl_ram_scheduler: RTL and testbench
=====================================

# curl_ram_scheduler

Sequencing controller for the Curl multicycle block-RAM state store. It owns both ports of a true dual-port RAM that holds two ping-pong copies of the sponge state, and gives the host port-A access while idle. On start it runs ROUNDS transform rounds: it streams operand word pairs from the current bank to the transform datapath and writes results into the other bank. It then flips banks and signals completion.

## Interface
Parameters:
- DATA_WIDTH, 54, bits per state word (27 trits × 2 bits)
- WORD_NUM, 27, state words per bank
- ADDR_WIDTH, $clog2(WORD_NUM), logical (host/bank-local) address width
- RAM_AW, $clog2(2*WORD_NUM), physical RAM address width; the RAM is instantiated with 2*WORD_NUM words
- B_OFFSET, 13, port-B operand distance: word (k+B_OFFSET) mod WORD_NUM, range 1..WORD_NUM-1
- ROUNDS, 81, rounds per start, ≥1
- DP_LAT, 0, datapath latency in cycles from o_dp_valid to i_dp_result, ≥0

Ports:
- i_clk  in  1  clock; one clock domain
- i_arst  in  1  reset; asynchronous, active-high
- i_start  in  1  start pulse; accepted only when o_busy=0
- i_host_we  in  1  host write enable; honoured only when idle
- i_host_addr  in  ADDR_WIDTH  host logical address
- i_host_data  in  DATA_WIDTH  host write data
- o_host_data  out  DATA_WIDTH  host read data; equals i_ram_data_a
- o_busy  out  1  high from start acceptance until return to IDLE
- o_done  out  1  one-cycle pulse when the final round completes
- o_ram_addr_a, o_ram_addr_b  out  RAM_AW  RAM addresses
- o_ram_we_a, o_ram_we_b  out  1  RAM write enables; o_ram_we_b is constant 0
- o_ram_data_a, o_ram_data_b  out  DATA_WIDTH  RAM write data; o_ram_data_b is constant 0
- i_ram_data_a, i_ram_data_b  in  DATA_WIDTH  RAM read data; 1-cycle registered read, write-first
- o_dp_valid  out  1  operand pair valid
- o_dp_a, o_dp_b  out  DATA_WIDTH  operands; equal i_ram_data_a/b
- i_dp_result  in  DATA_WIDTH  result word, sampled DP_LAT cycles after the matching o_dp_valid

## Operation
- Physical address = logical + (bank ? WORD_NUM : 0). Register `cur` selects the read bank; writes go to !cur.
- FSM states: IDLE, ISSUE, DRAIN, FLIP.
- IDLE:
  - Port A is driven from the host: addr=phys(cur, i_host_addr), we=i_host_we, data=i_host_data.
  - i_start moves the FSM to ISSUE and clears k, the write counter w, the round counter and the phase bit ph.
- ISSUE: ph toggles every cycle, starting at 0.
  - ph=0: read k on port A and (k+B_OFFSET) mod WORD_NUM on port B, both in bank cur. Then k++.
  - After the ph=0 cycle with k=WORD_NUM-1, go to DRAIN.
- Result path:
  - A DP_LAT-deep valid shift register marks when i_dp_result is due.
  - If the result is due on a ph=1 cycle, write it directly on port A at phys(!cur, w).
  - If it is due on a ph=0 cycle, capture it in a hold register and write it on the next cycle.
  - Each write increments w. Results are at least 2 cycles apart, so one hold register always suffices.
- DRAIN: ph keeps toggling. When w reaches WORD_NUM, go to FLIP.
- FLIP (1 cycle): cur ← !cur and round++.
  - If round == ROUNDS, go to IDLE and pulse o_done.
  - Otherwise go to ISSUE with k=w=ph=0.
- On return to IDLE the final state sits in the new cur bank; host reads are transparent.
- When not in IDLE: i_start and i_host_we are ignored, and port A/B reads never hit bank !cur.
- Reset (asynchronous, also mid-run): FSM → IDLE, cur=0, all counters and the hold register cleared. All outputs read 0 except the pass-throughs o_host_data, o_dp_a and o_dp_b. RAM contents are not cleared; a partially written bank is undefined.

## Timing
- Host read: address in cycle t → o_host_data valid in t+1.
- Round start at cycle 0: read k issued at 2k; o_dp_valid high at 2k+1.
- Write of word k: cycle 2k+1+DP_LAT if DP_LAT is even, 2k+2+DP_LAT if odd.
- Round period (ISSUE start to next ISSUE start) = 2*WORD_NUM+1+DP_LAT+(DP_LAT mod 2) cycles; 55 for defaults.
- o_done rises in the cycle after the last FLIP, i.e. the first IDLE cycle.
- o_busy falls together with the o_done pulse. An i_start in that cycle is accepted.

## Test plan
- Reset: assert i_arst mid-ISSUE → next sample shows o_busy=0, o_dp_valid=0, o_ram_we_a=0, cur=0. Host read of address 0 then returns bank-0 content.
- Host access: write word i = i*3 for i=0..26, read back → data matches, 1-cycle latency. A host write with o_busy=1 does not change RAM.
- ROUNDS=1, DP_LAT=0, i_dp_result=o_dp_a:
  - o_done pulse 56 cycles after the start cycle.
  - Host readback of words 0..26 equals the loaded values, now served from bank 1.
  - Check o_dp_b for k=20 equals word 6.
- ROUNDS=2, DP_LAT=3, result = o_dp_a+1 delayed 3 cycles:
  - Final words = load+2.
  - Round period 59 cycles; the hold register is exercised (writes on ph=1 only).
- i_start pulsed repeatedly while busy → exactly one run, one o_done pulse.
- ROUNDS=81, DP_LAT=0, identity datapath → o_done after 81×55+1 cycles; final bank cur=1 holds the original data.

Source files
------------

// File: rtl/curl_ram_scheduler.sv
// curl_ram_scheduler: ping-pong dual-port RAM sequencer for the Curl transform rounds.
// Ports: i_clk/i_arst clock and async reset; i_start launches ROUNDS rounds when idle;
// i_host_* / o_host_data give the host port-A access to bank cur while idle;
// o_busy/o_done report run status; o_ram_* / i_ram_data_* drive the true dual-port RAM;
// o_dp_valid/o_dp_a/o_dp_b feed operand pairs to the datapath, i_dp_result returns results.
module curl_ram_scheduler #(
  parameter int DATA_WIDTH = 54,
  parameter int WORD_NUM = 27,
  parameter int ADDR_WIDTH = $clog2(WORD_NUM),
  parameter int RAM_AW = $clog2(2 * WORD_NUM),
  parameter int B_OFFSET = 13,
  parameter int ROUNDS = 81,
  parameter int DP_LAT = 0
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_start,
  input  logic                  i_host_we,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_data,
  output logic [DATA_WIDTH-1:0] o_host_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [RAM_AW-1:0]     o_ram_addr_a,
  output logic [RAM_AW-1:0]     o_ram_addr_b,
  output logic                  o_ram_we_a,
  output logic                  o_ram_we_b,
  output logic [DATA_WIDTH-1:0] o_ram_data_a,
  output logic [DATA_WIDTH-1:0] o_ram_data_b,
  input  logic [DATA_WIDTH-1:0] i_ram_data_a,
  input  logic [DATA_WIDTH-1:0] i_ram_data_b,
  output logic                  o_dp_valid,
  output logic [DATA_WIDTH-1:0] o_dp_a,
  output logic [DATA_WIDTH-1:0] o_dp_b,
  input  logic [DATA_WIDTH-1:0] i_dp_result
);
  localparam int RW = $clog2(ROUNDS + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLIP} state_t;
  state_t st, nxt;
  logic cur, ph, done, hold_v, rd, due, wr, last_round, idle, host;
  logic [ADDR_WIDTH-1:0] k, kb;
  logic [ADDR_WIDTH:0] w, ks;
  logic [RW-1:0] round;
  logic [DP_LAT:0] pipe;
  logic [DATA_WIDTH-1:0] hold, wdata;
  function automatic logic [RAM_AW-1:0] phys(input logic bank, input logic [ADDR_WIDTH-1:0] a);
    return RAM_AW'(a) + (bank ? RAM_AW'(WORD_NUM) : '0);
  endfunction
  assign ks = {1'b0, k} + (ADDR_WIDTH+1)'(B_OFFSET);
  assign kb = ks >= (ADDR_WIDTH+1)'(WORD_NUM) ? ADDR_WIDTH'(ks - (ADDR_WIDTH+1)'(WORD_NUM)) : ADDR_WIDTH'(ks);
  assign idle = st == IDLE;
  assign host = idle && !i_arst;
  assign rd = st == ISSUE && !ph;
  // pipe[0] is o_dp_valid; pipe[DP_LAT] flags the cycle the matching result arrives
  assign due = pipe[DP_LAT];
  // results arriving on a ph=0 cycle are parked in hold and written on the following ph=1 cycle,
  // so port A is only ever written while it is not needed for an operand read
  assign wr = !idle && ((due && ph) || hold_v);
  assign wdata = hold_v ? hold : i_dp_result;
  assign last_round = round + 1'b1 == RW'(ROUNDS);
  always_comb begin
    nxt = st == IDLE  ? (i_start ? ISSUE : IDLE) :
          st == ISSUE ? (rd && k == ADDR_WIDTH'(WORD_NUM - 1) ? DRAIN : ISSUE) :
          st == DRAIN ? (wr && w == (ADDR_WIDTH+1)'(WORD_NUM - 1) ? FLIP : DRAIN) :
          (last_round ? IDLE : ISSUE);
  end
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      st <= IDLE;
      cur <= 1'b0;
      ph <= 1'b0;
      k <= '0;
      w <= '0;
      round <= '0;
      done <= 1'b0;
      hold_v <= 1'b0;
      hold <= '0;
      pipe <= '0;
    end else begin
      st <= nxt;
      ph <= (st == ISSUE || st == DRAIN) ? ~ph : 1'b0;
      k <= st != ISSUE ? '0 : rd ? k + 1'b1 : k;
      w <= (st == IDLE || st == FLIP) ? '0 : wr ? w + 1'b1 : w;
      round <= idle ? '0 : st == FLIP ? round + 1'b1 : round;
      cur <= st == FLIP ? ~cur : cur;
      done <= st == FLIP && last_round;
      hold_v <= due && !ph;
      hold <= due && !ph ? i_dp_result : hold;
      pipe[0] <= rd;
      for (int i = 1; i <= DP_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign o_ram_addr_a = host ? phys(cur, i_host_addr) : idle ? '0 :
                        wr ? phys(~cur, w[ADDR_WIDTH-1:0]) : phys(cur, k);
  assign o_ram_we_a = host ? i_host_we : wr;
  assign o_ram_data_a = host ? i_host_data : wr ? wdata : '0;
  assign o_ram_addr_b = idle ? '0 : phys(cur, kb);
  assign o_ram_we_b = 1'b0;
  assign o_ram_data_b = '0;
  assign o_host_data = i_ram_data_a;
  assign o_dp_a = i_ram_data_a;
  assign o_dp_b = i_ram_data_b;
  assign o_dp_valid = pipe[0];
  assign o_busy = !idle;
  assign o_done = done;
endmodule

// File: tb/tb_curl_ram_scheduler.sv
// tb_curl_ram_scheduler: scoreboard bench for three scheduler configurations sharing one host bus.
module tb_curl_ram_scheduler;
  localparam int DW = 54, N = 27, AW = 5, RAW = 6, BO = 13;
  typedef struct {int cyc; int addr; logic [DW-1:0] d;} wr_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rst;
  logic start, hwe, rd_req;
  logic rd_v = 1'b0;
  logic [1:0] sel;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hdata;
  logic [DW-1:0] hq [3], qa [3], qb [3], da [3], db [3], dpr [3], wda [3], wdb [3];
  logic busy [3], done [3], dpv [3], wea [3], web [3];
  logic [RAW-1:0] ra [3], rb [3];
  logic [DW-1:0] ram0 [64], ram1 [64], ram2 [64];
  logic [DW-1:0] d1, d2, d3;
  logic [DW-1:0] mdl [3][N];
  logic curb [3];
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [DW-1:0] exp_host [$];
  logic [2*DW-1:0] exp_op [$];
  wr_t exp_wr [$];
  int exp_done [$];
  curl_ram_scheduler #(.ROUNDS(1), .DP_LAT(0)) u0 (
    .i_clk(clk), .i_arst(rst[0]), .i_start(start && sel == 0), .i_host_we(hwe && sel == 0),
    .i_host_addr(haddr), .i_host_data(hdata), .o_host_data(hq[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_ram_addr_a(ra[0]), .o_ram_addr_b(rb[0]), .o_ram_we_a(wea[0]), .o_ram_we_b(web[0]),
    .o_ram_data_a(wda[0]), .o_ram_data_b(wdb[0]), .i_ram_data_a(qa[0]), .i_ram_data_b(qb[0]),
    .o_dp_valid(dpv[0]), .o_dp_a(da[0]), .o_dp_b(db[0]), .i_dp_result(dpr[0]));
  curl_ram_scheduler #(.ROUNDS(2), .DP_LAT(3)) u1 (
    .i_clk(clk), .i_arst(rst[1]), .i_start(start && sel == 1), .i_host_we(hwe && sel == 1),
    .i_host_addr(haddr), .i_host_data(hdata), .o_host_data(hq[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_ram_addr_a(ra[1]), .o_ram_addr_b(rb[1]), .o_ram_we_a(wea[1]), .o_ram_we_b(web[1]),
    .o_ram_data_a(wda[1]), .o_ram_data_b(wdb[1]), .i_ram_data_a(qa[1]), .i_ram_data_b(qb[1]),
    .o_dp_valid(dpv[1]), .o_dp_a(da[1]), .o_dp_b(db[1]), .i_dp_result(dpr[1]));
  curl_ram_scheduler #(.ROUNDS(81), .DP_LAT(0)) u2 (
    .i_clk(clk), .i_arst(rst[2]), .i_start(start && sel == 2), .i_host_we(hwe && sel == 2),
    .i_host_addr(haddr), .i_host_data(hdata), .o_host_data(hq[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_ram_addr_a(ra[2]), .o_ram_addr_b(rb[2]), .o_ram_we_a(wea[2]), .o_ram_we_b(web[2]),
    .o_ram_data_a(wda[2]), .o_ram_data_b(wdb[2]), .i_ram_data_a(qa[2]), .i_ram_data_b(qb[2]),
    .o_dp_valid(dpv[2]), .o_dp_a(da[2]), .o_dp_b(db[2]), .i_dp_result(dpr[2]));
  always @(posedge clk) begin
    if (wea[0]) ram0[ra[0]] <= wda[0];
    qa[0] <= wea[0] ? wda[0] : ram0[ra[0]];
    qb[0] <= ram0[rb[0]];
    if (wea[1]) ram1[ra[1]] <= wda[1];
    qa[1] <= wea[1] ? wda[1] : ram1[ra[1]];
    qb[1] <= ram1[rb[1]];
    if (wea[2]) ram2[ra[2]] <= wda[2];
    qa[2] <= wea[2] ? wda[2] : ram2[ra[2]];
    qb[2] <= ram2[rb[2]];
    d1 <= da[1] + 1'b1;
    d2 <= d1;
    d3 <= d2;
    rd_v <= rd_req;
    cyc <= cyc + 1;
  end
  assign dpr[0] = da[0];
  assign dpr[1] = d3;
  assign dpr[2] = da[2];
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    logic [2*DW-1:0] op;
    wr_t e;
    if (rd_v) begin
      if (exp_host.size() == 0) check("host_rd_unexpected", 1, 0);
      else check("host_rd", 64'(hq[sel]), 64'(exp_host.pop_front()));
    end
    if (dpv[sel]) begin
      check("port_b_we", {63'(wdb[sel]), web[sel]}, 0);
      if (exp_op.size() == 0) check("dp_unexpected", 1, 0);
      else begin
        op = exp_op.pop_front();
        check("dp_a", 64'(da[sel]), 64'(op[2*DW-1:DW]));
        check("dp_b", 64'(db[sel]), 64'(op[DW-1:0]));
      end
    end
    if (busy[sel] && wea[sel]) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = exp_wr.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
        check("wr_addr", 64'(ra[sel]), 64'(e.addr));
        check("wr_data", 64'(wda[sel]), 64'(e.d));
      end
    end
    if (done[sel]) begin
      if (exp_done.size() == 0) check("done_unexpected", 1, 0);
      else check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
      check("busy_with_done", 64'(busy[sel]), 0);
    end
  end
  task automatic host_write(int a, logic [DW-1:0] d);
    hwe = 1'b1;
    haddr = AW'(a);
    hdata = d;
    mdl[sel][a] = d;
    @(negedge clk);
    hwe = 1'b0;
  endtask
  task automatic host_read(int a);
    haddr = AW'(a);
    rd_req = 1'b1;
    exp_host.push_back(mdl[sel][a]);
    @(negedge clk);
    rd_req = 1'b0;
  endtask
  task automatic readback();
    for (int i = 0; i < N; i++) host_read(i);
    @(negedge clk);
  endtask
  task automatic load_random();
    for (int i = 0; i < N; i++) host_write(i, DW'({$urandom(), $urandom()}));
  endtask
  task automatic check_bank();
    hwe = 1'b0;
    haddr = '0;
    #1;
    check("cur_bank", 64'(ra[sel]), curb[sel] ? N : 0);
    @(negedge clk);
  endtask
  task automatic plan(int rounds, int lat, bit plus1);
    logic [DW-1:0] nx [N];
    int per = 2 * N + 1 + lat + lat % 2;
    int s = cyc;
    bit c = curb[sel];
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < N; k++) begin
        nx[k] = mdl[sel][k] + (plus1 ? DW'(1) : DW'(0));
        exp_op.push_back({mdl[sel][k], mdl[sel][(k + BO) % N]});
        exp_wr.push_back('{s + 1 + r * per + 2 * k + 1 + lat + lat % 2, c ? k : N + k, nx[k]});
      end
      for (int k = 0; k < N; k++) mdl[sel][k] = nx[k];
      c = !c;
    end
    curb[sel] = c;
    exp_done.push_back(s + rounds * per + 1);
  endtask
  task automatic run(int rounds, int lat, bit plus1, bit spam);
    int bud = rounds * (2 * N + 2 + lat) + 10;
    plan(rounds, lat, plus1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < bud && busy[sel]; i++) begin
      if (spam) begin
        start = 1'($urandom);
        hwe = 1'($urandom);
        haddr = AW'($urandom_range(0, N - 1));
        hdata = DW'({$urandom(), $urandom()});
      end
      @(negedge clk);
    end
    start = 1'b0;
    hwe = 1'b0;
    check("run_finished", 64'(busy[sel]), 0);
    @(negedge clk);
  endtask
  initial begin
    rst = '1;
    start = 1'b0;
    hwe = 1'b0;
    rd_req = 1'b0;
    haddr = '0;
    hdata = '0;
    sel = 2'd0;
    curb = '{1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", 64'(busy[d]), 0);
      check("rst_dpv", 64'(dpv[d]), 0);
      check("rst_done", 64'(done[d]), 0);
      check("rst_we_a", 64'(wea[d]), 0);
    end
    rst = '0;
    @(negedge clk);
    for (int i = 0; i < N; i++) host_write(i, DW'(i * 3));
    readback();
    run(1, 0, 1'b0, 1'b0);
    check_bank();
    readback();
    load_random();
    run(1, 0, 1'b0, 1'b1);
    check_bank();
    readback();
    plan(1, 0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    rst[0] = 1'b1;
    exp_op.delete();
    exp_wr.delete();
    exp_done.delete();
    curb[0] = 1'b0;
    @(negedge clk);
    check("arst_busy", 64'(busy[0]), 0);
    check("arst_dpv", 64'(dpv[0]), 0);
    check("arst_we_a", 64'(wea[0]), 0);
    check("arst_done", 64'(done[0]), 0);
    check("arst_addr_a", 64'(ra[0]), 0);
    rst[0] = 1'b0;
    @(negedge clk);
    check_bank();
    readback();
    sel = 2'd1;
    @(negedge clk);
    load_random();
    readback();
    run(2, 3, 1'b1, 1'b1);
    check_bank();
    readback();
    sel = 2'd2;
    @(negedge clk);
    load_random();
    run(81, 0, 1'b0, 1'b0);
    check_bank();
    readback();
    check("host_left", 64'(exp_host.size()), 0);
    check("ops_left", 64'(exp_op.size()), 0);
    check("writes_left", 64'(exp_wr.size()), 0);
    check("done_left", 64'(exp_done.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
